// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU; define ALU_SEQ_MUL_EN to build the iterative multiplier (opcode 11)
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             err,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WV = WIDTH'(WIDTH);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, res_c, sra_w;
    logic [3:0] op_r;
    logic [WIDTH:0] add_w;
    logic [SHW-1:0] shamt;
    logic big, carry_c, ovf_c, err_c, is_mul, mul_last, accept, done;
    assign accept = state == IDLE && in_valid;
    assign done = state == EXEC && (!is_mul || mul_last);
    assign add_w = {1'b0, a_r} + {1'b0, b_r};
    assign shamt = b_r[SHW-1:0];
    assign big = b_r >= WV;
    assign sra_w = $signed(a_r) >>> shamt;
    assign in_ready = state == IDLE;
    assign busy = state != IDLE;
    assign out_valid = state == RESP;
`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH:0] psum;
    logic [CW-1:0] cnt;
    assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? a_r : {WIDTH{1'b0}}};
    assign acc_nx = {psum, acc[WIDTH-1:1]};
    assign is_mul = op_r == 4'd11;
    assign mul_last = cnt == CW'(1);
    // shift-add multiplier: multiplier sits in the low half and is consumed one bit per cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= {{WIDTH{1'b0}}, b};
            cnt <= CW'(WIDTH);
        end else if (state == EXEC && is_mul) begin
            acc <= acc_nx;
            cnt <= cnt - CW'(1);
        end
    end
`else
    assign is_mul = 1'b0;
    assign mul_last = 1'b0;
`endif
    // operation decode; MUL takes the final accumulator step so it lands with the last iteration
    always_comb begin
        res_c = '0;
        carry_c = 1'b0;
        ovf_c = 1'b0;
        err_c = 1'b0;
        case (op_r)
            4'd0: begin
                res_c = add_w[WIDTH-1:0];
                carry_c = add_w[WIDTH];
                ovf_c = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_w[WIDTH-1] != a_r[WIDTH-1]);
            end
            4'd1: begin
                res_c = a_r - b_r;
                carry_c = a_r < b_r;
                ovf_c = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_c[WIDTH-1] != a_r[WIDTH-1]);
            end
            4'd2: res_c = ~a_r;
            4'd3: res_c = big ? '0 : a_r << shamt;
            4'd4: res_c = big ? '0 : a_r >> shamt;
            4'd5: res_c = a_r & b_r;
            4'd6: res_c = a_r | b_r;
            4'd7: res_c = {{(WIDTH-1){1'b0}}, a_r < b_r};
            4'd8: res_c = {{(WIDTH-1){1'b0}}, $signed(a_r) < $signed(b_r)};
            4'd9: res_c = big ? {WIDTH{a_r[WIDTH-1]}} : sra_w;
            4'd10: res_c = a_r ^ b_r;
`ifdef ALU_SEQ_MUL_EN
            4'd11: begin
                res_c = acc_nx[WIDTH-1:0];
                carry_c = |acc_nx[2*WIDTH-1:WIDTH];
            end
`endif
            default: err_c = 1'b1;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end
    // next-state: accept in IDLE, finish in EXEC, hand off in RESP
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = in_valid ? EXEC : IDLE;
            EXEC: state_nx = done ? RESP : EXEC;
            RESP: state_nx = out_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    // operand capture on accept; result and flags captured once when the op completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            zero <= 1'b0;
            negative <= 1'b0;
            carry <= 1'b0;
            overflow <= 1'b0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                a_r <= a;
                b_r <= b;
                op_r <= alu_ctrl;
            end
            if (done) begin
                result <= res_c;
                zero <= res_c == '0;
                negative <= res_c[WIDTH-1];
                carry <= carry_c;
                overflow <= ovf_c;
                err <= err_c;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [3:0] alu_ctrl = '0;
    logic in_ready, out_valid, zero, negative, carry, overflow, err, busy;
    logic [15:0] result;
    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // expected {result, zero, negative, carry, overflow, err} from plain arithmetic
    function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        logic c, v, e;
        int u, sx, sy, ss;
        logic [31:0] p;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            4'd0: begin
                u = int'(x) + int'(y); ss = sx + sy;
                r = 16'(u); c = u > 65535; v = (ss > 32767) || (ss < -32768);
            end
            4'd1: begin
                u = int'(x) - int'(y); ss = sx - sy;
                r = 16'(u); c = x < y; v = (ss > 32767) || (ss < -32768);
            end
            4'd2: r = ~x;
            4'd3: if (y < 16) r = x << y;
            4'd4: if (y < 16) r = x >> y;
            4'd5: r = x & y;
            4'd6: r = x | y;
            4'd7: r = (x < y) ? 16'd1 : 16'd0;
            4'd8: r = (sx < sy) ? 16'd1 : 16'd0;
            4'd9: begin
                if (y >= 16) r = x[15] ? 16'hFFFF : 16'h0000;
                else begin
                    ss = sx >>> y;
                    r = 16'(ss);
                end
            end
            4'd10: r = x ^ y;
`ifdef ALU_SEQ_MUL_EN
            4'd11: begin
                p = 32'(x) * 32'(y);
                r = p[15:0]; c = p[31:16] != 0;
            end
`endif
            default: e = 1'b1;
        endcase
        p = '0;
        return {r, r == 16'h0, r[15], c, v, e};
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
        if (op == 4'd11) return 16;
`endif
        return 1;
    endfunction

    // one transaction: accept, scramble inputs, wait for result, then consume it
    task automatic run_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                          output int lat, output logic [20:0] obs);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1; alu_ctrl = op; a = x; b = y;
        @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); alu_ctrl = 4'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        obs = {result, zero, negative, carry, overflow, err};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; alu_ctrl = 4'd0; a = 16'h1111; b = 16'h2222;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, busy, result, zero, negative, carry, overflow, err} !== 23'h0) begin
            errors++;
            $display("FAIL reset_state: got %h exp 0", {out_valid, busy, result, zero, negative, carry, overflow, err});
        end
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: got ready/busy/valid %b exp 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_directed();
        logic [3:0] ops [10] = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd9, 4'd3, 4'd4, 4'd13, 4'd11, 4'd11};
        logic [15:0] xs [10] = '{16'h7FFF, 16'h0003, 16'hFFFE, 16'hFFFE, 16'h8000, 16'h0001, 16'h8000, 16'h1234, 16'h0100, 16'h0007};
        logic [15:0] ys [10] = '{16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'd20, 16'd16, 16'd15, 16'h5678, 16'h0100, 16'h0009};
`ifdef ALU_SEQ_MUL_EN
        logic [20:0] ex [10] = '{{16'h8000, 5'b01010}, {16'hFFFE, 5'b01100}, {16'h0001, 5'b00000},
                                 {16'h0000, 5'b10000}, {16'hFFFF, 5'b01000}, {16'h0000, 5'b10000},
                                 {16'h0001, 5'b00000}, {16'h0000, 5'b10001}, {16'h0000, 5'b10100},
                                 {16'h003F, 5'b00000}};
        int el [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 16, 16};
`else
        logic [20:0] ex [10] = '{{16'h8000, 5'b01010}, {16'hFFFE, 5'b01100}, {16'h0001, 5'b00000},
                                 {16'h0000, 5'b10000}, {16'hFFFF, 5'b01000}, {16'h0000, 5'b10000},
                                 {16'h0001, 5'b00000}, {16'h0000, 5'b10001}, {16'h0000, 5'b10001},
                                 {16'h0000, 5'b10001}};
        int el [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
        int lat;
        logic [20:0] obs;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], xs[i], ys[i], lat, obs);
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL directed_%0d op%0d: got %h exp %h", i, ops[i], obs, ex[i]);
            end
            checks++;
            if (lat !== el[i]) begin
                errors++;
                $display("FAIL directed_lat_%0d op%0d: got %0d exp %0d", i, ops[i], lat, el[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [20:0] obs;
        logic [3:0] op;
        logic [15:0] x, y;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            x = 16'($urandom);
            y = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            run_op(op, x, y, lat, obs);
            checks++;
            if (obs !== model(op, x, y)) begin
                errors++;
                $display("FAIL random_%0d op%0d a=%h b=%h: got %h exp %h", i, op, x, y, obs, model(op, x, y));
            end
            checks++;
            if (lat !== exp_lat(op)) begin
                errors++;
                $display("FAIL random_lat_%0d op%0d: got %0d exp %0d", i, op, lat, exp_lat(op));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] e1, e2;
        int w;
        e1 = model(4'd0, 16'h1234, 16'h1111);
        e2 = model(4'd10, 16'hA5A5, 16'h0FF0);
        in_valid = 1'b1; alu_ctrl = 4'd0; a = 16'h1234; b = 16'h1111;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1; alu_ctrl = 4'd10; a = 16'hA5A5; b = 16'h0FF0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({result, in_ready, out_valid} !== {e1[20:5], 2'b01}) begin
                errors++;
                $display("FAIL stall_%0d: got result/ready/valid %h exp %h", i, {result, in_ready, out_valid}, {e1[20:5], 2'b01});
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL release_idle: got ready/valid %b exp 10", {in_ready, out_valid});
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({busy, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL release_accept: got busy/ready %b exp 10", {busy, in_ready});
        end
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if ({result, zero, negative, carry, overflow, err} !== e2) begin
            errors++;
            $display("FAIL after_stall: got %h exp %h", {result, zero, negative, carry, overflow, err}, e2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        logic [20:0] obs;
        run_op(4'd0, 16'd2, 16'd3, lat, obs);
        checks++;
        if (obs[20:5] !== 16'd5) begin
            errors++;
            $display("FAIL pre_reset_add: got %h exp 0005", obs[20:5]);
        end
        in_valid = 1'b1; alu_ctrl = 4'd11; a = 16'h1234; b = 16'h0011;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; alu_ctrl = 4'd0;
        @(negedge clk);
        checks++;
        if ({out_valid, busy, result, zero, negative, carry, overflow, err} !== 23'h0) begin
            errors++;
            $display("FAIL mid_mul_reset: got %h exp 0", {out_valid, busy, result, zero, negative, carry, overflow, err});
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_valid: got busy %b exp 0", busy);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_ready: got %b exp 100", {in_ready, busy, out_valid});
        end
        run_op(4'd0, 16'd2, 16'd3, lat, obs);
        checks++;
        if (obs !== {16'd5, 5'b00000}) begin
            errors++;
            $display("FAIL post_reset_add: got %h exp %h", obs, {16'd5, 5'b00000});
        end
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL post_reset_lat: got %0d exp 1", lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit combinational ALU.
- Registers operands on a valid/ready input handshake and executes one operation:
  - single-cycle for logic, add/sub, shift and compare ops;
  - iterative shift-add for MUL.
- Presents a registered result plus zero/carry/overflow/negative/err flags on a valid/ready output handshake.
- Sits between the decode/operand-fetch stage and writeback. Both sides may stall.

Parameters:
- WIDTH, 16, datapath width in bits; legal range 4..64.
- SHW, $clog2(WIDTH), derived; not overridable. Low bits of b used as shift amount when b < WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept (state IDLE)
- a  in  WIDTH  source operand 1
- b  in  WIDTH  source operand 2 / shift amount
- alu_ctrl  in  4  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- negative  out  1  result[WIDTH-1]
- carry  out  1  ADD carry-out; SUB borrow; MUL high-half nonzero; else 0
- overflow  out  1  signed overflow for ADD/SUB; else 0
- err  out  1  illegal alu_ctrl
- busy  out  1  state != IDLE

Behaviour:
- Opcodes:
  - 0 ADD; 1 SUB (a-b); 2 NOT a; 3 SLL; 4 SRL; 5 AND; 6 OR.
  - 7 SLTU: unsigned a<b gives 1, else 0. This keeps the legacy encoding.
  - 8 SLT signed; 9 SRA; 10 XOR; 11 MUL (low WIDTH bits).
  - 12-15 illegal.
- Shifts:
  - Amount is the full unsigned value of b.
  - b >= WIDTH: SLL/SRL give 0; SRA gives all copies of a[WIDTH-1].
- FSM states: IDLE, EXEC, RESP.
  - IDLE: in_ready=1. in_valid&&in_ready at an edge latches a, b, alu_ctrl and goes to EXEC.
  - EXEC, non-MUL op: one cycle. Result and flags registered, then go to RESP.
  - EXEC, MUL: WIDTH cycles of shift-add on a 2*WIDTH accumulator, with a count-down counter. Goes to RESP at the edge where the counter expires.
  - RESP: out_valid=1; result and flags stable. out_ready=1 at an edge goes to IDLE.
- Latency:
  - Accept at edge k gives out_valid high after edge k+1 for non-MUL ops, or after edge k+WIDTH for MUL.
  - No bypass. The RESP→IDLE cycle cannot accept, so peak throughput is one op per 3 cycles.
- Handshake rules:
  - Inputs are ignored unless state=IDLE.
  - Operand changes after acceptance have no effect.
  - out_valid never drops without out_ready.
  - result and flags hold their last values in IDLE; only out_valid qualifies them.
- Flags:
  - ADD: carry = bit WIDTH of a+b; overflow = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
  - SUB: carry = (a<b unsigned); overflow = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
  - MUL: carry = |product[2*WIDTH-1:WIDTH].
  - Illegal op: result=0, err=1, zero=1, other flags 0, latency 1.
- Reset (rst_n=0 at an edge, any state, including mid-MUL):
  - state=IDLE, counter=0, result=0.
  - All flags 0, out_valid=0, busy=0.
  - In-flight op is discarded; no stale result is ever presented.
  - in_valid is ignored while rst_n=0.
  - in_ready=1 in the first cycle after release.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 11 performs iterative MUL as above (WIDTH-cycle latency).
- Undefined: multiplier, accumulator and counter are not built. Opcode 11 is treated as illegal (err=1, result=0, latency 1).

Test Plan:
- ADD, WIDTH=16, a=0x7FFF, b=0x0001 → result=0x8000, overflow=1, carry=0, negative=1, zero=0; out_valid exactly 1 cycle after accept.
- SUB a=0x0003, b=0x0005 → result=0xFFFE, carry=1, negative=1. Then SLT a=0xFFFE, b=0x0001 → 1. SLTU on the same operands → 0.
- SRA a=0x8000, b=20 → 0xFFFF. SLL a=0x0001, b=16 → 0x0000, zero=1. SRL a=0x8000, b=15 → 0x0001.
- Backpressure:
  - Complete an op, then hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands.
  - Required: result stable, in_ready=0, out_valid=1, new request not accepted.
  - On out_ready=1, the next op is accepted 1 cycle later.
- MUL:
  - With ALU_SEQ_MUL_EN: a=0x0100, b=0x0100 → result=0x0000, carry=1, zero=1, out_valid 16 cycles after accept. Then a=0x0007, b=0x0009 → 0x003F, carry=0.
  - Without the macro: alu_ctrl=11 → err=1, result=0, latency 1. alu_ctrl=13 → err=1 in both builds.
- Reset mid-MUL: rst_n=0 at cycle 5 of a MUL → next cycle out_valid=0, busy=0, result=0; in_ready=1 after release. A following ADD 2+3 returns 5.
